// File: rtl/udp_pkg.sv
// Shared definitions for the raw-FIFO packet controller: FSM encoding and
// the width of the packet length carried to the UDP transmitter.
package udp_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/raw_fifo_pkt_ctrl_if.sv
// Byte stream bundle between the skid buffer and the transmitter side.
// Handshake: a byte transfers on a rising clock edge where valid and ready
// are both 1; once valid is raised, data/last/valid hold until that edge;
// ready may change freely and never depends on valid.
interface raw_fifo_pkt_ctrl_if;

  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/pkt_skid_buf.sv
// Two-entry output buffer. Entry 0 is always the head presented on the
// stream; entry 1 catches a byte whose read was already in flight when the
// consumer stalled. The writer guarantees it never pushes into a full buffer.
module pkt_skid_buf (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [7:0]         push_data,
  input  logic               push_last,
  output logic [1:0]         count,
  raw_fifo_pkt_ctrl_if.master tx
);

  logic [7:0] data0;
  logic [7:0] data1;
  logic       last0;
  logic       last1;
  logic       pop;

  assign tx.valid = (count != 2'd0);
  assign tx.data  = data0;
  assign tx.last  = last0 & tx.valid;
  assign pop      = tx.valid & tx.ready;

  // Shift-register storage: pops move entry 1 forward, pushes fill the first free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data0 <= '0;
      data1 <= '0;
      last0 <= 1'b0;
      last1 <= 1'b0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            data0 <= push_data;
            last0 <= push_last;
          end else begin
            data1 <= push_data;
            last1 <= push_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          data0 <= data1;
          last0 <= last1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            data0 <= push_data;
            last0 <= push_last;
          end else begin
            data0 <= data1;
            last0 <= last1;
            data1 <= push_data;
            last1 <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/raw_fifo_pkt_ctrl.sv
// Packetiser between a non-showahead raw byte FIFO and a UDP transmitter.
// Waits for a full payload (or a flush request with residual bytes), asks
// the transmitter for a packet of that length, then streams exactly that
// many bytes from the FIFO through a two-entry skid buffer.
module raw_fifo_pkt_ctrl
  import udp_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int PAYLOAD_LEN = 512
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] fifo_usedw,
  input  logic              fifo_full,
  input  logic [7:0]        fifo_q,
  output logic              fifo_rdreq,
  input  logic              frame_end,
  output logic              pkt_req,
  output logic [LEN_W-1:0]  pkt_len,
  input  logic              pkt_ack,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  output logic              tx_last,
  input  logic              tx_ready,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam logic [31:0]      PAYLOAD_W = 32'(PAYLOAD_LEN);
  localparam logic [LEN_W-1:0] PAYLOAD_L = LEN_W'(PAYLOAD_LEN);

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] reads_left;
  logic             flush_pend;
  logic             inflight;
  logic             inflight_last;
  logic [1:0]       buf_count;
  logic             pop;
  logic [2:0]       occ;
  logic [31:0]      usedw_ext;

  raw_fifo_pkt_ctrl_if tx_if ();

  assign tx_if.ready = tx_ready;
  assign tx_data     = tx_if.data;
  assign tx_valid    = tx_if.valid;
  assign tx_last     = tx_if.last;
  assign dbg_state   = state;
  assign usedw_ext   = 32'(fifo_usedw);

  // Occupancy counts the byte leaving this cycle as gone so a full-rate
  // stream keeps one read in flight while one byte sits in the buffer.
  assign pop        = tx_valid & tx_ready;
  assign occ        = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rdreq = (state == ST_STREAM) && (reads_left != '0) && (occ < 3'd2);

  pkt_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_q),
    .push_last (inflight_last),
    .count     (buf_count),
    .tx        (tx_if)
  );

  // FIFO data lands one cycle after the strobe; remember whether it was the final read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= fifo_rdreq;
      inflight_last <= fifo_rdreq && (reads_left == LEN_W'(1));
    end
  end

  // Packet FSM with registered request/length/busy outputs and sticky flush request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      len        <= '0;
      reads_left <= '0;
      pkt_req    <= 1'b0;
      pkt_len    <= '0;
      busy       <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fifo_full || (usedw_ext >= PAYLOAD_W)) begin
            len     <= PAYLOAD_L;
            pkt_len <= PAYLOAD_L;
            pkt_req <= 1'b1;
            busy    <= 1'b1;
            state   <= ST_REQ;
          end else if (flush_pend && (usedw_ext != 32'd0)) begin
            len        <= LEN_W'(fifo_usedw);
            pkt_len    <= LEN_W'(fifo_usedw);
            pkt_req    <= 1'b1;
            busy       <= 1'b1;
            flush_pend <= 1'b0;
            state      <= ST_REQ;
          end else if (flush_pend) begin
            flush_pend <= 1'b0;
          end
        end
        ST_REQ: begin
          if (pkt_ack) begin
            pkt_req    <= 1'b0;
            reads_left <= len;
            state      <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (fifo_rdreq) begin
            reads_left <= reads_left - LEN_W'(1);
          end
          if (pop && tx_last) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
      if (frame_end) begin
        flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_raw_fifo_pkt_ctrl.sv
// Directed bench for raw_fifo_pkt_ctrl: behavioural non-showahead FIFO,
// expected-byte queue, one task per scenario.
module tb_raw_fifo_pkt_ctrl;
  import udp_pkg::*;

  localparam int ADDR_W = 10;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // main DUT (PAYLOAD_LEN 512)
  logic [ADDR_W-1:0] fifo_usedw;
  logic              fifo_full;
  logic [7:0]        fifo_q = 8'h00;
  logic              fifo_rdreq;
  logic              frame_end;
  logic              pkt_req;
  logic [15:0]       pkt_len;
  logic              pkt_ack;
  logic              busy;
  logic [1:0]        dbg_state;
  raw_fifo_pkt_ctrl_if tx_bus ();

  // second DUT (PAYLOAD_LEN 1024) for the full-flag case
  logic [ADDR_W-1:0] usedw2;
  logic              full2;
  logic [7:0]        q2;
  logic              rdreq2;
  logic              frame_end2;
  logic              pkt_req2;
  logic [15:0]       pkt_len2;
  logic              ack2;
  logic              busy2;
  logic [1:0]        dbg2;
  raw_fifo_pkt_ctrl_if tx_bus2 ();

  raw_fifo_pkt_ctrl #(.ADDR_W(ADDR_W), .PAYLOAD_LEN(512)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_usedw(fifo_usedw), .fifo_full(fifo_full),
    .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq), .frame_end(frame_end),
    .pkt_req(pkt_req), .pkt_len(pkt_len), .pkt_ack(pkt_ack),
    .tx_data(tx_bus.data), .tx_valid(tx_bus.valid), .tx_last(tx_bus.last),
    .tx_ready(tx_bus.ready), .busy(busy), .dbg_state(dbg_state)
  );

  raw_fifo_pkt_ctrl #(.ADDR_W(ADDR_W), .PAYLOAD_LEN(1024)) dut2 (
    .clk(clk), .rst_n(rst_n), .fifo_usedw(usedw2), .fifo_full(full2),
    .fifo_q(q2), .fifo_rdreq(rdreq2), .frame_end(frame_end2),
    .pkt_req(pkt_req2), .pkt_len(pkt_len2), .pkt_ack(ack2),
    .tx_data(tx_bus2.data), .tx_valid(tx_bus2.valid), .tx_last(tx_bus2.last),
    .tx_ready(tx_bus2.ready), .busy(busy2), .dbg_state(dbg2)
  );

  // FIFO model: bench owns the write side, the always block owns the read side
  logic [7:0] mem [0:4095];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_count = 0;
  int underflow = 0;
  int bad_reads = 0;

  assign fifo_usedw = 10'(wr_ptr - rd_ptr);

  // non-showahead read port; reset empties the FIFO
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= wr_ptr;
      fifo_q <= 8'h00;
    end else if (fifo_rdreq) begin
      rd_count <= rd_count + 1;
      if (dbg_state != ST_STREAM) bad_reads <= bad_reads + 1;
      if (rd_ptr == wr_ptr) underflow <= underflow + 1;
      else begin
        fifo_q <= mem[rd_ptr % 4096];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  // scoreboard
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int checks = 0;
  int errors = 0;
  int first_iter, last_iter, stall_bad, last_count;
  bit seen, done, aborted;
  logic [15:0] len_seen;
  int held_bad, bad, first_bad, rd_base;

  // driver tasks
  task automatic push_bytes(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = base + 8'(i * 7) + 8'(i / 256);
      mem[wr_ptr % 4096] = b;
      exp_q.push_back(b);
      wr_ptr++;
    end
  endtask

  task automatic do_request(input int ack_delay, output bit s, output logic [15:0] l, output int hb);
    s = 0; hb = 0; l = '0;
    for (int i = 0; i < 60 && !s; i++) begin
      @(negedge clk);
      if (pkt_req === 1'b1) s = 1;
    end
    l = pkt_len;
    if (s) begin
      for (int d = 1; d <= ack_delay; d++) begin
        @(negedge clk);
        if (pkt_req !== 1'b1 || pkt_len !== l) hb++;
        if (d == ack_delay) pkt_ack = 1'b1;
      end
    end
  endtask

  task automatic stream_packet(input int max_cyc, input bit rand_ready, input int inject_at,
                               input int inject_n, input int abort_at, output bit dn, output bit ab);
    bit prev_stall;
    logic [7:0] prev_data;
    logic prev_last;
    got_q.delete();
    first_iter = -1; last_iter = -1; stall_bad = 0; last_count = 0;
    dn = 0; ab = 0; prev_stall = 0; prev_data = '0; prev_last = 0;
    for (int it = 1; it <= max_cyc && !dn && !ab; it++) begin
      @(negedge clk);
      pkt_ack = 1'b0;
      frame_end = (it == inject_at);
      if (it == inject_at) push_bytes(inject_n, 8'hA0);
      tx_bus.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (prev_stall && (tx_bus.valid !== 1'b1 || tx_bus.data !== prev_data || tx_bus.last !== prev_last))
        stall_bad++;
      prev_stall = tx_bus.valid && !tx_bus.ready;
      prev_data = tx_bus.data;
      prev_last = tx_bus.last;
      if (tx_bus.valid === 1'b1 && tx_bus.ready === 1'b1) begin
        if (first_iter < 0) first_iter = it;
        last_iter = it;
        got_q.push_back(tx_bus.data);
        if (tx_bus.last === 1'b1) begin
          last_count++;
          dn = 1;
        end
        if (abort_at > 0 && got_q.size() == abort_at) ab = 1;
      end
    end
    frame_end = 1'b0;
  endtask

  task automatic diff_data(input int n, output int nbad, output int fbad);
    nbad = 0; fbad = -1;
    for (int i = 0; i < n; i++) begin
      logic [7:0] e;
      if (exp_q.size() == 0 || i >= got_q.size()) begin
        nbad++;
        if (fbad < 0) fbad = i;
      end else begin
        e = exp_q.pop_front();
        if (got_q[i] !== e) begin
          nbad++;
          if (fbad < 0) fbad = i;
        end
      end
    end
  endtask

  // scenario tasks
  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({fifo_rdreq, pkt_req, pkt_len, tx_bus.valid, tx_bus.last, tx_bus.data, busy, dbg_state} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {fifo_rdreq, pkt_req, pkt_len, tx_bus.valid, tx_bus.last, tx_bus.data, busy, dbg_state}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({busy, pkt_req, fifo_rdreq, pkt_req2} !== 4'b0) begin
      errors++; $display("FAIL reset_release got %b want 0000", {busy, pkt_req, fifo_rdreq, pkt_req2}); end
  endtask

  task automatic test_full_packet;
    rd_base = rd_count;
    push_bytes(512, 8'h10);
    do_request(1, seen, len_seen, held_bad);
    checks++; if (!seen || len_seen !== 16'd512) begin errors++; $display("FAIL s1_len got %0d want 512 (seen %0d)", len_seen, seen); end
    checks++; if (held_bad != 0) begin errors++; $display("FAIL s1_req_hold got %0d want 0", held_bad); end
    stream_packet(3000, 0, 0, 0, 0, done, aborted);
    checks++; if (!done || got_q.size() != 512) begin errors++; $display("FAIL s1_count got %0d want 512", got_q.size()); end
    checks++; if (first_iter != 3) begin errors++; $display("FAIL s1_latency got %0d want 3", first_iter); end
    checks++; if (last_iter - first_iter != 511) begin errors++; $display("FAIL s1_contiguous got %0d want 511", last_iter - first_iter); end
    diff_data(512, bad, first_bad);
    checks++; if (bad != 0) begin errors++; $display("FAIL s1_data got %0d bad bytes (first %0d) want 0", bad, first_bad); end
    checks++; if (rd_count - rd_base != 512) begin errors++; $display("FAIL s1_rdreq got %0d want 512", rd_count - rd_base); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL s1_idle got busy %b state %0d want 0 0", busy, dbg_state); end
  endtask

  task automatic test_flush;
    int req_seen;
    rd_base = rd_count;
    req_seen = 0;
    push_bytes(37, 8'h80);
    repeat (20) begin
      @(negedge clk);
      if (pkt_req !== 1'b0 || busy !== 1'b0) req_seen++;
    end
    checks++; if (req_seen != 0) begin errors++; $display("FAIL s2_no_req got %0d cycles want 0", req_seen); end
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
    do_request(3, seen, len_seen, held_bad);
    checks++; if (!seen || len_seen !== 16'd37) begin errors++; $display("FAIL s2_len got %0d want 37", len_seen); end
    checks++; if (held_bad != 0) begin errors++; $display("FAIL s2_req_hold got %0d want 0", held_bad); end
    checks++; if (dut.flush_pend !== 1'b0) begin errors++; $display("FAIL s2_flush_clear got %b want 0", dut.flush_pend); end
    stream_packet(500, 0, 0, 0, 0, done, aborted);
    checks++; if (!done || got_q.size() != 37 || last_count != 1) begin errors++; $display("FAIL s2_count got %0d want 37", got_q.size()); end
    diff_data(37, bad, first_bad);
    checks++; if (bad != 0) begin errors++; $display("FAIL s2_data got %0d bad bytes (first %0d) want 0", bad, first_bad); end
    checks++; if (rd_count - rd_base != 37) begin errors++; $display("FAIL s2_rdreq got %0d want 37", rd_count - rd_base); end
  endtask

  task automatic test_full_flag;
    int n;
    n = 0;
    @(negedge clk);
    full2 = 1'b1;
    while (pkt_req2 !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++; if (pkt_req2 !== 1'b1 || pkt_len2 !== 16'd1024) begin errors++; $display("FAIL s3_len got %0d want 1024", pkt_len2); end
    full2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy2 !== 1'b1 || rdreq2 !== 1'b0 || pkt_len2 !== 16'd1024) begin
      errors++; $display("FAIL s3_hold got busy %b rdreq %b len %0d want 1 0 1024", busy2, rdreq2, pkt_len2); end
  endtask

  task automatic test_backpressure;
    rd_base = rd_count;
    push_bytes(512, 8'h33);
    do_request(1, seen, len_seen, held_bad);
    checks++; if (!seen || len_seen !== 16'd512) begin errors++; $display("FAIL s4_len got %0d want 512", len_seen); end
    stream_packet(5000, 1, 0, 0, 0, done, aborted);
    checks++; if (!done || got_q.size() != 512) begin errors++; $display("FAIL s4_count got %0d want 512", got_q.size()); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL s4_stall_stable got %0d want 0", stall_bad); end
    diff_data(512, bad, first_bad);
    checks++; if (bad != 0) begin errors++; $display("FAIL s4_data got %0d bad bytes (first %0d) want 0", bad, first_bad); end
    checks++; if (rd_count - rd_base != 512) begin errors++; $display("FAIL s4_rdreq got %0d want 512", rd_count - rd_base); end
  endtask

  task automatic test_back_to_back;
    push_bytes(512, 8'h55);
    do_request(1, seen, len_seen, held_bad);
    checks++; if (!seen || len_seen !== 16'd512) begin errors++; $display("FAIL s5_len1 got %0d want 512", len_seen); end
    stream_packet(3000, 0, 50, 100, 0, done, aborted);
    checks++; if (!done || got_q.size() != 512) begin errors++; $display("FAIL s5_count1 got %0d want 512", got_q.size()); end
    diff_data(512, bad, first_bad);
    checks++; if (bad != 0) begin errors++; $display("FAIL s5_data1 got %0d bad bytes (first %0d) want 0", bad, first_bad); end
    do_request(1, seen, len_seen, held_bad);
    checks++; if (!seen || len_seen !== 16'd100) begin errors++; $display("FAIL s5_len2 got %0d want 100", len_seen); end
    stream_packet(1000, 0, 0, 0, 0, done, aborted);
    checks++; if (!done || got_q.size() != 100) begin errors++; $display("FAIL s5_count2 got %0d want 100", got_q.size()); end
    diff_data(100, bad, first_bad);
    checks++; if (bad != 0) begin errors++; $display("FAIL s5_data2 got %0d bad bytes (first %0d) want 0", bad, first_bad); end
  endtask

  task automatic test_reset_mid;
    push_bytes(512, 8'h07);
    do_request(1, seen, len_seen, held_bad);
    stream_packet(3000, 0, 0, 0, 200, done, aborted);
    checks++; if (!aborted) begin errors++; $display("FAIL s6_reach200 got %0d bytes want 200", got_q.size()); end
    rst_n = 1'b0;
    #1;
    checks++; if ({fifo_rdreq, pkt_req, pkt_len, tx_bus.valid, tx_bus.last, tx_bus.data, busy} !== '0) begin
      errors++; $display("FAIL s6_async_clear got %h want 0", {fifo_rdreq, pkt_req, pkt_len, tx_bus.valid, tx_bus.last, tx_bus.data, busy}); end
    rd_base = rd_count;
    exp_q.delete();
    repeat (3) @(negedge clk);
    checks++; if (rd_count != rd_base) begin errors++; $display("FAIL s6_no_reads got %0d want %0d", rd_count, rd_base); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL s6_restart_idle got busy %b state %0d want 0 0", busy, dbg_state); end
    rd_base = rd_count;
    push_bytes(512, 8'hC0);
    do_request(1, seen, len_seen, held_bad);
    checks++; if (!seen || len_seen !== 16'd512) begin errors++; $display("FAIL s6_len got %0d want 512", len_seen); end
    stream_packet(3000, 0, 0, 0, 0, done, aborted);
    checks++; if (!done || got_q.size() != 512) begin errors++; $display("FAIL s6_count got %0d want 512", got_q.size()); end
    diff_data(512, bad, first_bad);
    checks++; if (bad != 0) begin errors++; $display("FAIL s6_data got %0d bad bytes (first %0d) want 0", bad, first_bad); end
    checks++; if (rd_count - rd_base != 512) begin errors++; $display("FAIL s6_rdreq got %0d want 512", rd_count - rd_base); end
  endtask

  // sequence
  initial begin
    fifo_full = 1'b0; frame_end = 1'b0; pkt_ack = 1'b0; tx_bus.ready = 1'b1;
    full2 = 1'b0; usedw2 = '0; q2 = 8'h00; frame_end2 = 1'b0; ack2 = 1'b0; tx_bus2.ready = 1'b0;
    test_reset();
    test_full_packet();
    test_flush();
    test_full_flag();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    checks++; if (underflow != 0 || bad_reads != 0) begin
      errors++; $display("FAIL fifo_protocol got underflow %0d idle_reads %0d want 0 0", underflow, bad_reads); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #1000000;
    $display("FAIL timeout got no completion want finish");
    $fatal(1, "timeout");
  end

endmodule
